// File: rtl/posit_pkg.sv
// Shared constants and FSM state type for the 32-bit, es=3 posit decoder.
package posit_pkg;

    localparam int unsigned N  = 32;
    localparam int unsigned ES = 3;

    localparam logic [31:0] ZERO_PATTERN = 32'h0000_0000;
    localparam logic [31:0] NAR_PATTERN  = 32'h8000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StDecode,
        StDone
    } state_t;

endpackage

// File: rtl/posit_regime_counter.sv
// Leading-run encoder: length of the run of bits equal to word[30], counted from the MSB.
module posit_regime_counter (
    input  logic [30:0] word,
    output logic [4:0]  run_len,
    output logic        polarity
);

    logic [30:0] diff;

    assign polarity = word[30];

    // A set bit in diff marks the first bit that breaks the run; the highest one wins.
    always_comb begin
        diff    = polarity ? ~word : word;
        run_len = 5'd31;
        for (int i = 0; i < 31; i++) begin
            if (diff[i]) begin
                run_len = 5'(30 - i);
            end
        end
    end

endmodule

// File: rtl/posit_decoder.sv
// Multi-cycle posit (es=3) decoder with start/done/received handshake.
module posit_decoder
    import posit_pkg::*;
#(
    parameter int unsigned N  = 32,
    parameter int unsigned ES = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  posit_num,
    input  logic          start,
    input  logic          received,
    output logic          sign,
    output logic          done,
    output logic          ZERO,
    output logic          NAR,
    output logic [5:0]    k,
    output logic [ES-1:0] exp_value,
    output logic [N-1:0]  mantissa
);

    state_t      state_q;
    logic [31:0] word_q;
    logic        sign_q;
    logic        zero_q;
    logic        nar_q;
    logic        phase_q;
    logic [4:0]  m_q;
    logic        r_q;

    logic [4:0]  run_len;
    logic        polarity;
    logic [5:0]  shamt;
    logic [30:0] rem;
    logic [5:0]  k_next;

    posit_regime_counter u_regime (
        .word     (word_q[30:0]),
        .run_len  (run_len),
        .polarity (polarity)
    );

    // Drop the regime run plus its terminator; exponent then fraction are left-aligned in rem.
    assign shamt  = {1'b0, m_q} + 6'd1;
    assign rem    = word_q[30:0] << shamt;
    assign k_next = r_q ? ({1'b0, m_q} - 6'd1) : (6'd0 - {1'b0, m_q});

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            word_q    <= '0;
            sign_q    <= 1'b0;
            zero_q    <= 1'b0;
            nar_q     <= 1'b0;
            phase_q   <= 1'b0;
            m_q       <= '0;
            r_q       <= 1'b0;
            sign      <= 1'b0;
            done      <= 1'b0;
            ZERO      <= 1'b0;
            NAR       <= 1'b0;
            k         <= '0;
            exp_value <= '0;
            mantissa  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        word_q  <= posit_num;
                        state_q <= StConvert;
                    end
                end
                StConvert: begin
                    sign_q  <= word_q[31];
                    zero_q  <= (word_q == ZERO_PATTERN);
                    nar_q   <= (word_q == NAR_PATTERN);
                    if (word_q[31]) begin
                        word_q <= ~word_q + 32'd1;
                    end
                    phase_q <= 1'b0;
                    state_q <= StDecode;
                end
                StDecode: begin
                    // Run length is registered first so the encoder and barrel shift
                    // sit on separate cycles.
                    if (!phase_q) begin
                        m_q     <= run_len;
                        r_q     <= polarity;
                        phase_q <= 1'b1;
                    end else begin
                        sign <= sign_q;
                        ZERO <= zero_q;
                        NAR  <= nar_q;
                        if (zero_q || nar_q) begin
                            k         <= '0;
                            exp_value <= '0;
                            mantissa  <= '0;
                        end else begin
                            k         <= k_next;
                            exp_value <= rem[30:28];
                            mantissa  <= {1'b1, rem[27:0], 3'b000};
                        end
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (received) begin
                        done    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_posit_decoder.sv
// Table-driven, scoreboarded bench for posit_decoder.
module tb_posit_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] posit_num;
    logic        start;
    logic        received;
    logic        sign;
    logic        done;
    logic        ZERO;
    logic        NAR;
    logic [5:0]  k;
    logic [2:0]  exp_value;
    logic [31:0] mantissa;

    typedef struct packed {
        logic [31:0] in;
        logic        sgn;
        logic        zero;
        logic        nar;
        logic [5:0]  k;
        logic [2:0]  e;
        logic [31:0] man;
    } vec_t;

    vec_t vecs [12];
    vec_t sb [$];

    int n_tests = 0;
    int n_fail  = 0;

    posit_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .posit_num (posit_num),
        .start     (start),
        .received  (received),
        .sign      (sign),
        .done      (done),
        .ZERO      (ZERO),
        .NAR       (NAR),
        .k         (k),
        .exp_value (exp_value),
        .mantissa  (mantissa)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called #1 after an edge; counts edges until done is seen high.
    task automatic wait_done(input string name, input int lat);
        int cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({name, "_latency"}, 64'(cyc), 64'(lat));
    endtask

    task automatic compare_out(input string name);
        vec_t v;
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            v = sb.pop_front();
            chk({name, "_sign"}, 64'(sign), 64'(v.sgn));
            chk({name, "_zero"}, 64'(ZERO), 64'(v.zero));
            chk({name, "_nar"}, 64'(NAR), 64'(v.nar));
            chk({name, "_k"}, 64'(k), 64'(v.k));
            chk({name, "_exp"}, 64'(exp_value), 64'(v.e));
            chk({name, "_mant"}, 64'(mantissa), 64'(v.man));
        end
    endtask

    task automatic ack(input string name);
        @(negedge clk);
        received = 1'b1;
        @(posedge clk);
        #1;
        received = 1'b0;
        chk({name, "_done_drop"}, 64'(done), 64'd0);
    endtask

    task automatic run_vec(input string name, input vec_t v, input int ack_delay);
        @(negedge clk);
        posit_num = v.in;
        start     = 1'b1;
        sb.push_back(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(name, 3);
        compare_out(name);
        repeat (ack_delay) @(posedge clk);
        #1;
        chk({name, "_done_hold"}, 64'({done, mantissa}), 64'({1'b1, v.man}));
        ack(name);
    endtask

    initial begin
        bit seen_done;

        //          in            sgn   zero  nar   k        e     man
        vecs[0]  = '{32'h8000_0000, 1'b1, 1'b0, 1'b1, 6'd0,    3'd0, 32'h0000_0000};
        vecs[1]  = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 6'd0,    3'd0, 32'h0000_0000};
        vecs[2]  = '{32'h007F_F97E, 1'b0, 1'b0, 1'b0, -6'sd8,  3'd7, 32'hFF97_E000};
        vecs[3]  = '{32'hC33F_FFFF, 1'b1, 1'b0, 1'b0, -6'sd1,  3'd7, 32'h9800_0020};
        vecs[4]  = '{32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, -6'sd29, 3'd0, 32'h8000_0000};
        vecs[5]  = '{32'hAAAB_2000, 1'b1, 1'b0, 1'b0, 6'd0,    3'd5, 32'hAA9C_0000};
        vecs[6]  = '{32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 6'd30,   3'd0, 32'h8000_0000};
        vecs[7]  = '{32'h7FFF_FFFE, 1'b0, 1'b0, 1'b0, 6'd29,   3'd0, 32'h8000_0000};
        vecs[8]  = '{32'h0000_0001, 1'b0, 1'b0, 1'b0, -6'sd30, 3'd0, 32'h8000_0000};
        vecs[9]  = '{32'h4800_0000, 1'b0, 1'b0, 1'b0, 6'd0,    3'd2, 32'h8000_0000};
        vecs[10] = '{32'h4000_0000, 1'b0, 1'b0, 1'b0, 6'd0,    3'd0, 32'h8000_0000};
        vecs[11] = '{32'h0000_0001, 1'b0, 1'b0, 1'b0, -6'sd30, 3'd0, 32'h8000_0000};

        rst       = 1'b0;
        start     = 1'b0;
        received  = 1'b0;
        posit_num = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_outs", 64'({sign, ZERO, NAR, k, exp_value, mantissa}), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // NaR with a slow consumer, then the rest of the table.
        run_vec("nar", vecs[0], 10);
        for (int i = 1; i < 10; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i], i % 3);
        end

        // start held high across the acknowledge launches a second decode at once.
        @(negedge clk);
        posit_num = vecs[10].in;
        start     = 1'b1;
        sb.push_back(vecs[10]);
        @(posedge clk);
        #1;
        wait_done("cs0", 3);
        compare_out("cs0");
        @(negedge clk);
        received  = 1'b1;
        posit_num = vecs[11].in;
        sb.push_back(vecs[11]);
        @(posedge clk);
        #1;
        received = 1'b0;
        chk("cs0_done_drop", 64'(done), 64'd0);
        wait_done("cs1", 4);
        start = 1'b0;
        compare_out("cs1");
        ack("cs1");

        // received is ignored while busy, and reset during CONVERT aborts the decode.
        @(negedge clk);
        posit_num = 32'h007F_F97E;
        start     = 1'b1;
        received  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b1;
        received  = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen_done = 1'b1;
        end
        chk("abort_no_done", 64'(seen_done), 64'd0);
        chk("abort_outs", 64'({sign, ZERO, NAR, k, exp_value, mantissa}), 64'd0);

        // Decoder recovers after the abort.
        run_vec("recover", vecs[3], 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/posit_decoder.md
Name: posit_decoder

Overview:
- Decodes a 32-bit posit (es=3) into sign, regime value k, exponent and normalized mantissa.
- Sits between posit storage/encoder output and posit arithmetic datapaths.
- Flags zero and NaR.
- Uses a start/done/received handshake with fixed latency.

Parameters:
- N, 32, posit width (only the default is supported and verified).
- ES, 3, exponent field width (only the default is supported and verified).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-low.
- posit_num  input  32  posit operand; sampled when a decode is accepted.
- start  input  1  request decode (level-sensitive in IDLE).
- received  input  1  consumer acknowledge; releases done.
- sign  output  1  posit sign bit (bit 31 of input).
- done  output  1  result valid; held until acknowledged.
- ZERO  output  1  input was 0x00000000.
- NAR  output  1  input was 0x80000000.
- k  output  6  signed two's-complement regime value.
- exp_value  output  3  exponent field.
- mantissa  output  32  hidden bit at [31], fraction left-aligned below it, zero-filled LSBs.

Behaviour:
- Reset (rst=0 at an edge): state IDLE. All outputs 0: sign, done, ZERO, NAR, k, exp_value, mantissa. Reset mid-decode aborts the decode.
- FSM states: IDLE, CONVERT, DECODE, DONE.
- IDLE: on an edge with start=1, register posit_num and go to CONVERT.
- CONVERT: set sign=bit31. If bit31=1, replace the word by its two's complement. Detect zero and NaR on the original word. Go to DECODE.
- DECODE: compute regime, exponent and fraction. Register all outputs, set done=1, go to DONE.
- Latency: done rises 3 edges after the accepting edge.
- DONE: done stays 1 and outputs hold stable. On an edge with received=1, done goes to 0 and the state returns to IDLE. received is ignored outside DONE.
- After returning to IDLE, a still-high start begins a new decode.
- Data outputs keep their last values until the next DECODE overwrites them.
- Regime:
  - r = bit30 of the converted word; m = run length of identical bits starting at bit30 (1..31).
  - r=1 gives k=m-1 (max 30, for 0x7FFFFFFF). r=0 gives k=-m.
  - The terminating bit, if present, is skipped.
- Exponent: the next 3 bits after the terminator. If fewer than 3 bits remain, missing LSBs are 0.
- Fraction: all remaining bits (0..26 bits). mantissa = {1'b1, fraction, zero padding}.
- Zero input: ZERO=1, NAR=0, sign=0, k=0, exp_value=0, mantissa=0.
- NaR input: NAR=1, ZERO=0, sign=1, k=0, exp_value=0, mantissa=0.
- ZERO and NAR are cleared for any other input.
- Specials use the same 3-cycle latency and the same handshake.

Decomposition:
- Shared package posit_pkg: N=32, ES=3, ZERO_PATTERN=32'h0, NAR_PATTERN=32'h8000_0000, FSM state typedef.
- One sub-module: posit_regime_counter. It takes a 31-bit word and returns run length m and polarity r; implement as a priority/leading-run encoder.
- All shifting and output registering stay in posit_decoder.

Test Plan:
- Reset, then 0x80000000 with start=1 and received raised 10 cycles later -> done=1 at accept+3 edges; NAR=1, sign=1, k=0, exp=0, mantissa=0; done drops the edge after received=1.
- 0x00000000 -> ZERO=1, NAR=0, sign=0, k=0, exp=0, mantissa=0.
- 0x007FF97E -> sign=0, k=-8, exp=7, mantissa=0xFF97E000.
- 0xC33FFFFF (complement 0x3CC00001) -> sign=1, k=-1, exp=7, mantissa=0x98000020.
- 0xFFFFFFFE -> sign=1, k=-29, exp=0 (truncated), mantissa=0x80000000.
- 0xAAAB2000 -> sign=1, k=0, exp=5, mantissa=0xAA9C0000. Also 0x7FFFFFFF -> k=30, exp=0, mantissa=0x80000000. Also rst=0 asserted during CONVERT -> done never rises, all outputs 0.
